// File: rtl/entrada_pkg.sv
// Shared definitions for the keypad digit-entry path.
//   estado_t    : key filter FSM encoding (OCIOSO, FILTRO, SOLTA)
//   LARGURA_COD : width of one key code nibble
package entrada_pkg;

  localparam int LARGURA_COD = 4;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    FILTRO = 2'd1,
    SOLTA  = 2'd2
  } estado_t;

endpackage

// File: rtl/entrada_digitos_sincronizador.sv
// Two-flop synchroniser for a bus of signals sampled together.
// Ports:
//   clk   : destination clock, rising edge
//   reset : synchronous active-high reset, clears both stages
//   d     : asynchronous input bus (LARGURA bits)
//   q     : synchronised output bus, two cycles behind d
module sincronizador #(
  parameter int LARGURA = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LARGURA-1:0] d,
  output logic [LARGURA-1:0] q
);

  logic [LARGURA-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/entrada_digitos.sv
// Keypad digit-entry stage. Filters the encoder's valid strobe, accepts one
// key code per physical press, shifts codes into a NUM_DIGITOS-nibble working
// register and commits the word to valor on a confirma rising edge.
// Ports:
//   clk, reset   : clock (rising edge), synchronous active-high reset
//   BCD          : key code from the priority encoder (asynchronous)
//   dado_valido  : encoder valid level (asynchronous)
//   confirma     : commit request, acts on its rising edge
//   limpa        : clears the entry while high
//   valor        : committed word, newest digit in [3:0]
//   digitos      : number of digits currently entered
//   pronto       : one-cycle pulse when valor updates
//   cheio        : high while the working register is full
//   erro         : one-cycle pulse when a key is accepted while full
//   estado       : current filter FSM state (debug visibility)
//
// Handshake: there is no backpressure. A key is "offered" by the encoder via
// the dado_valido level; this block accepts it once after it has been stable
// long enough and ignores it until the level drops again. pronto is a pure
// strobe qualifying valor for exactly one cycle; valor then holds.
module entrada_digitos
  import entrada_pkg::*;
#(
  parameter int NUM_DIGITOS = 4,
  parameter int ESTAVEL     = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [LARGURA_COD-1:0]             BCD,
  input  logic                               dado_valido,
  input  logic                               confirma,
  input  logic                               limpa,
  output logic [LARGURA_COD*NUM_DIGITOS-1:0] valor,
  output logic [3:0]                         digitos,
  output logic                               pronto,
  output logic                               cheio,
  output logic                               erro,
  output logic [1:0]                         estado
);

  localparam int         LW          = LARGURA_COD * NUM_DIGITOS;
  localparam logic [7:0] ESTAVEL_CNT = 8'(ESTAVEL);
  localparam logic [3:0] MAX_DIG     = 4'(NUM_DIGITOS);

  // ---------------------------------------------------------------------
  // Synchronised copies of the encoder outputs
  // ---------------------------------------------------------------------
  logic [LARGURA_COD:0]   sinc_q;
  logic                   v_s;
  logic [LARGURA_COD-1:0] c_s;

  sincronizador #(.LARGURA(LARGURA_COD + 1)) u_sinc (
    .clk   (clk),
    .reset (reset),
    .d     ({dado_valido, BCD}),
    .q     (sinc_q)
  );

  assign v_s = sinc_q[LARGURA_COD];
  assign c_s = sinc_q[LARGURA_COD-1:0];

  // ---------------------------------------------------------------------
  // Filter FSM
  // ---------------------------------------------------------------------
  estado_t                estado_q, estado_d;
  logic [7:0]             cnt, cnt_d;
  logic [LARGURA_COD-1:0] c_ref, c_ref_d;
  logic                   aceita;

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= OCIOSO;
      cnt      <= '0;
      c_ref    <= '0;
    end else begin
      estado_q <= estado_d;
      cnt      <= cnt_d;
      c_ref    <= c_ref_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt;
    c_ref_d  = c_ref;
    aceita   = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (v_s) begin
          c_ref_d  = c_s;
          cnt_d    = 8'd1;
          estado_d = FILTRO;
        end
      end
      FILTRO: begin
        if (!v_s) begin
          estado_d = OCIOSO;
        end else if (c_s != c_ref) begin
          // Code moved while held: restart the stability count on the new code.
          c_ref_d = c_s;
          cnt_d   = 8'd1;
        end else if (cnt == ESTAVEL_CNT) begin
          aceita   = 1'b1;
          estado_d = SOLTA;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      SOLTA: begin
        // A held key never repeats; only a release re-arms the filter.
        if (!v_s) estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
    // Clearing also swallows any key currently being held.
    if (limpa) estado_d = SOLTA;
  end

  assign estado = estado_q;

  // ---------------------------------------------------------------------
  // Accumulator and commit
  // ---------------------------------------------------------------------
  logic [LW-1:0] trab, trab_d;
  logic [3:0]    dig_d;
  logic          conf_ant;
  logic          commit;
  logic          erro_d;

  // Commit only on a rising edge of confirma with something entered.
  assign commit = confirma && !conf_ant && (digitos != 4'd0) && !limpa;

  always_comb begin
    trab_d = trab;
    dig_d  = digitos;
    erro_d = 1'b0;
    if (limpa || commit) begin
      trab_d = '0;
      dig_d  = 4'd0;
    end else if (aceita) begin
      if (digitos == MAX_DIG) begin
        erro_d = 1'b1;
      end else begin
        trab_d = (trab << LARGURA_COD) | LW'(c_ref);
        dig_d  = digitos + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      trab     <= '0;
      digitos  <= 4'd0;
      cheio    <= 1'b0;
      erro     <= 1'b0;
      pronto   <= 1'b0;
      valor    <= '0;
      // Starts high so a confirma held through reset is not seen as an edge.
      conf_ant <= 1'b1;
    end else begin
      trab     <= trab_d;
      digitos  <= dig_d;
      cheio    <= (dig_d == MAX_DIG);
      erro     <= erro_d;
      pronto   <= commit;
      conf_ant <= confirma;
      if (commit) valor <= trab;
    end
  end

endmodule

// File: tb/tb_entrada_digitos.sv
module tb_entrada_digitos;

  localparam int NUM = 4;
  localparam int EST = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  bcd;
  logic        dado_valido;
  logic        confirma;
  logic        limpa;
  logic [15:0] valor;
  logic [3:0]  digitos;
  logic        pronto;
  logic        cheio;
  logic        erro;
  logic [1:0]  estado;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  entrada_digitos #(.NUM_DIGITOS(NUM), .ESTAVEL(EST)) dut (
    .clk         (clk),
    .reset       (reset),
    .BCD         (bcd),
    .dado_valido (dado_valido),
    .confirma    (confirma),
    .limpa       (limpa),
    .valor       (valor),
    .digitos     (digitos),
    .pronto      (pronto),
    .cheio       (cheio),
    .erro        (erro),
    .estado      (estado)
  );

  // ---------------- reference model ----------------
  // Sync delay as a two-deep history; key acceptance as a run length of
  // identical valid samples: a press is taken when the run reaches EST+1
  // samples, and the filter re-arms only after a sampled release.
  logic [3:0]  exp_q[$];
  logic [4:0]  s1, s2;
  int          run;
  bit          armed;
  logic [3:0]  rcode;
  logic [15:0] m_valor;
  bit          m_pronto, m_erro, prev_conf;

  function automatic logic [15:0] pack_q();
    logic [15:0] v = '0;
    foreach (exp_q[i]) v = (v << 4) | 16'(exp_q[i]);
    return v;
  endfunction

  always @(posedge clk) begin
    bit acc;
    if (reset) begin
      s1 = '0; s2 = '0; run = 0; armed = 1; rcode = '0;
      exp_q.delete();
      m_valor = '0; m_pronto = 0; m_erro = 0; prev_conf = 1;
    end else begin
      acc = 0; m_pronto = 0; m_erro = 0;
      if (!s2[4]) begin
        run = 0; armed = 1;
      end else if (armed) begin
        if (run == 0 || s2[3:0] != rcode) begin
          rcode = s2[3:0]; run = 1;
        end else begin
          run++;
        end
        if (run == EST + 1) begin acc = 1; armed = 0; end
      end
      s2 = s1;
      s1 = {dado_valido, bcd};
      if (limpa) begin
        exp_q.delete(); armed = 0; run = 0;
      end else if (confirma && !prev_conf && exp_q.size() > 0) begin
        m_valor = pack_q(); m_pronto = 1; exp_q.delete();
      end else if (acc) begin
        if (exp_q.size() == NUM) m_erro = 1;
        else exp_q.push_back(rcode);
      end
      prev_conf = confirma;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_key(input logic [3:0] code, input int hold, input int rel);
    bcd = code; dado_valido = 1'b1;
    cyc(hold);
    dado_valido = 1'b0;
    cyc(rel);
  endtask

  task automatic clear_entry();
    limpa = 1'b1; cyc(1);
    limpa = 1'b0; cyc(3);
  endtask

  task automatic pulse_confirma();
    confirma = 1'b1; cyc(1);
    confirma = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; bcd = '0; dado_valido = 0; confirma = 0; limpa = 0;
    cyc(3);
    n_tests++;
    if ({valor, digitos, pronto, cheio, erro} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valor=%h dig=%0d pronto=%b cheio=%b erro=%b, want all 0",
               valor, digitos, pronto, cheio, erro);
    end
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic test_latency();
    int first = 0;
    bcd = 4'h1; dado_valido = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      if (i == 11) dado_valido = 1'b0;
      cyc(1);
      if (digitos == 4'd1 && first == 0) first = i;
    end
    n_tests++;
    if (first !== 7) begin
      n_fail++; $display("FAIL latency: got %0d cycles, want 7", first);
    end
    n_tests++;
    if (digitos !== 4'd1) begin
      n_fail++; $display("FAIL no_repeat: got digitos=%0d, want 1", digitos);
    end
  endtask

  task automatic test_confirm();
    clear_entry();
    press_key(4'h5, 8, 4);
    press_key(4'h9, 8, 4);
    press_key(4'h3, 8, 4);
    press_key(4'h7, 8, 4);
    n_tests++;
    if (cheio !== 1'b1 || digitos !== 4'd4) begin
      n_fail++; $display("FAIL full_before_commit: got cheio=%b dig=%0d, want 1/4", cheio, digitos);
    end
    pulse_confirma();
    n_tests++;
    if (pronto !== 1'b1 || valor !== 16'h5937) begin
      n_fail++; $display("FAIL commit: got pronto=%b valor=%h, want 1/5937", pronto, valor);
    end
    n_tests++;
    if (digitos !== 4'd0 || cheio !== 1'b0) begin
      n_fail++; $display("FAIL commit_clear: got dig=%0d cheio=%b, want 0/0", digitos, cheio);
    end
    cyc(1);
    n_tests++;
    if (pronto !== 1'b0 || valor !== 16'h5937) begin
      n_fail++; $display("FAIL pronto_pulse: got pronto=%b valor=%h, want 0/5937", pronto, valor);
    end
  endtask

  task automatic test_glitch();
    int first = 0;
    press_key(4'h2, 3, 8);
    n_tests++;
    if (digitos !== 4'd0) begin
      n_fail++; $display("FAIL glitch: got digitos=%0d, want 0", digitos);
    end
    bcd = 4'h6; dado_valido = 1'b1;
    cyc(4);
    bcd = 4'hE;
    for (int i = 1; i <= 10; i++) begin
      cyc(1);
      if (digitos != 4'd0 && first == 0) first = i;
    end
    dado_valido = 1'b0;
    cyc(4);
    n_tests++;
    if (first !== 7 || digitos !== 4'd1) begin
      n_fail++; $display("FAIL code_change: got at=%0d dig=%0d, want 7/1", first, digitos);
    end
    pulse_confirma();
    n_tests++;
    if (valor !== 16'h000E) begin
      n_fail++; $display("FAIL code_change_value: got %h, want 000e", valor);
    end
  endtask

  task automatic test_overflow();
    int n_erro = 0;
    press_key(4'h1, 8, 4);
    press_key(4'h2, 8, 4);
    press_key(4'h3, 8, 4);
    press_key(4'h4, 8, 4);
    bcd = 4'hB; dado_valido = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i == 9) dado_valido = 1'b0;
      cyc(1);
      if (erro) n_erro++;
    end
    n_tests++;
    if (n_erro !== 1 || digitos !== 4'd4 || valor !== 16'h000E) begin
      n_fail++; $display("FAIL overflow: got erro_pulses=%0d dig=%0d valor=%h, want 1/4/000e",
                         n_erro, digitos, valor);
    end
    pulse_confirma();
    n_tests++;
    if (valor !== 16'h1234 || pronto !== 1'b1) begin
      n_fail++; $display("FAIL overflow_commit: got valor=%h pronto=%b, want 1234/1", valor, pronto);
    end
    cyc(1);
  endtask

  task automatic test_limpa();
    int n_pronto = 0;
    confirma = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      if (pronto) n_pronto++;
    end
    confirma = 1'b0;
    cyc(1);
    n_tests++;
    if (n_pronto !== 0) begin
      n_fail++; $display("FAIL empty_commit: got %0d pronto pulses, want 0", n_pronto);
    end
    press_key(4'hF, 8, 4);
    n_tests++;
    if (digitos !== 4'd1) begin
      n_fail++; $display("FAIL enter_f: got digitos=%0d, want 1", digitos);
    end
    limpa = 1'b1; confirma = 1'b1;
    cyc(1);
    limpa = 1'b0;
    n_tests++;
    if (digitos !== 4'd0 || pronto !== 1'b0 || valor !== 16'h1234) begin
      n_fail++; $display("FAIL limpa_priority: got dig=%0d pronto=%b valor=%h, want 0/0/1234",
                         digitos, pronto, valor);
    end
    cyc(1);
    n_tests++;
    if (pronto !== 1'b0) begin
      n_fail++; $display("FAIL limpa_no_late_commit: got pronto=%b, want 0", pronto);
    end
    confirma = 1'b0;
    cyc(1);
  endtask

  task automatic test_reset_mid();
    int n_pronto = 0;
    press_key(4'h2, 8, 4);
    press_key(4'h3, 8, 4);
    bcd = 4'h9; dado_valido = 1'b1;
    cyc(4);
    reset = 1'b1; confirma = 1'b1;
    cyc(1);
    n_tests++;
    if ({valor, digitos, pronto, cheio, erro} !== '0) begin
      n_fail++; $display("FAIL reset_mid: got valor=%h dig=%0d pronto=%b cheio=%b erro=%b, want all 0",
                         valor, digitos, pronto, cheio, erro);
    end
    reset = 1'b0; dado_valido = 1'b0;
    cyc(2);
    bcd = 4'h8; dado_valido = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i == 9) dado_valido = 1'b0;
      cyc(1);
      if (pronto) n_pronto++;
    end
    n_tests++;
    if (n_pronto !== 0 || digitos !== 4'd1) begin
      n_fail++; $display("FAIL confirma_through_reset: got pronto_pulses=%0d dig=%0d, want 0/1",
                         n_pronto, digitos);
    end
    confirma = 1'b0; cyc(1);
    pulse_confirma();
    n_tests++;
    if (valor !== 16'h0008 || pronto !== 1'b1) begin
      n_fail++; $display("FAIL commit_after_reset: got valor=%h pronto=%b, want 0008/1", valor, pronto);
    end
    cyc(1);
  endtask

  task automatic test_random();
    int hold_left = 0;
    for (int c = 0; c < 600; c++) begin
      if (hold_left == 0) begin
        dado_valido = ($urandom_range(0, 9) < 6);
        bcd         = 4'($urandom_range(0, 15));
        hold_left   = $urandom_range(1, 9);
      end
      hold_left--;
      confirma = ($urandom_range(0, 24) == 0);
      limpa    = ($urandom_range(0, 59) == 0);
      cyc(1);
      n_tests++;
      if (digitos !== 4'(exp_q.size()) || cheio !== (exp_q.size() == NUM)) begin
        n_fail++; $display("FAIL rnd_count c=%0d: got dig=%0d cheio=%b, want %0d/%b",
                           c, digitos, cheio, exp_q.size(), exp_q.size() == NUM);
      end
      n_tests++;
      if (pronto !== m_pronto || erro !== m_erro) begin
        n_fail++; $display("FAIL rnd_pulse c=%0d: got pronto=%b erro=%b, want %b/%b",
                           c, pronto, erro, m_pronto, m_erro);
      end
      n_tests++;
      if (valor !== m_valor) begin
        n_fail++; $display("FAIL rnd_valor c=%0d: got %h, want %h", c, valor, m_valor);
      end
    end
    dado_valido = 1'b0; confirma = 1'b0; limpa = 1'b0;
    cyc(2);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1; bcd = '0; dado_valido = 0; confirma = 0; limpa = 0;
    #1;
    test_reset();
    test_latency();
    test_confirm();
    test_glitch();
    test_overflow();
    test_limpa();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
